// File: rtl/irda_sir_encoder.sv
// IrDA SIR transmit encoder: turns one UART bit per OSR oversampling ticks into an
// IR pulse (zero bits only), either a tick-ratio window or a fixed clk-cycle width.
module irda_sir_encoder #(
   parameter int unsigned OSR        = 16,
   parameter int unsigned PULSE_W    = 3,
   parameter int unsigned PULSE_OFS  = 0,
   parameter int unsigned FIX_CYC    = 16,
   parameter bit          INVERT_OUT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic baud16_en,
   input  logic bit_valid,
   input  logic bit_data,
   input  logic mode_fixed,
   output logic bit_ready,
   output logic busy,
   output logic txd
);

   localparam int unsigned TW = $clog2(OSR);
   localparam int unsigned FW = 10;
   localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
   localparam logic [TW-1:0] TICK_OFS  = TW'(PULSE_OFS);
   localparam logic [TW:0]   WIN_LO    = (TW+1)'(PULSE_OFS);
   localparam logic [TW:0]   WIN_W     = (TW+1)'(PULSE_W);
   localparam logic [FW-1:0] FIX_LOAD  = FW'(FIX_CYC);

   typedef enum logic {S_IDLE, S_BIT} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [FW-1:0] fix_q, fix_d;
   logic          bit_q, bit_d;
   logic          mode_q, mode_d;
   logic          end_bit_c;
   logic          xfer_c;
   logic          ofs_hit_c;
   logic [TW:0]   win_rel_c;
   logic          window_c;

   // Next-state, handshake and pulse-window decode
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      mode_d    = mode_q;
      fix_d     = (fix_q != '0) ? fix_q - FW'(1) : '0;
      ofs_hit_c = 1'b0;
      end_bit_c = (state_q == S_BIT) && (tick_q == TICK_LAST) && baud16_en;
      bit_ready = (state_q == S_IDLE) || end_bit_c;
      xfer_c    = bit_valid && bit_ready;

      if (xfer_c) begin
         state_d   = S_BIT;
         tick_d    = '0;
         bit_d     = bit_data;
         mode_d    = mode_fixed;
         ofs_hit_c = (PULSE_OFS == 0);
      end else if (end_bit_c) begin
         state_d = S_IDLE;
         tick_d  = '0;
      end else if ((state_q == S_BIT) && baud16_en) begin
         tick_d    = tick_q + TW'(1);
         ofs_hit_c = (tick_d == TICK_OFS);
      end

      // Fixed pulse never outlives its bit; a fresh bit may reload it at tick 0
      if (end_bit_c) begin
         fix_d = '0;
      end
      if (ofs_hit_c && !bit_d && mode_d) begin
         fix_d = FIX_LOAD;
      end

      // Offset-relative tick wraps high when below PULSE_OFS, so one compare suffices
      win_rel_c = (TW+1)'({1'b0, tick_q} - WIN_LO);
      if (mode_q) begin
         window_c = (fix_q != '0);
      end else begin
         window_c = (state_q == S_BIT) && !bit_q && (win_rel_c < WIN_W);
      end
   end

   assign busy = (state_q == S_BIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         fix_q   <= '0;
         bit_q   <= 1'b1;
         mode_q  <= 1'b0;
         txd     <= INVERT_OUT;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         fix_q   <= fix_d;
         bit_q   <= bit_d;
         mode_q  <= mode_d;
         txd     <= INVERT_OUT ^ window_c;
      end
   end

endmodule

// File: tb/tb_irda_sir_encoder.sv
// Directed bench for irda_sir_encoder: five parameterisations share one stimulus,
// each scenario task checks the instance(s) it targets.
module tb_irda_sir_encoder;

   logic clk;
   logic rst_n;
   logic baud16_en;
   logic bit_valid;
   logic bit_data;
   logic mode_fixed;
   logic txd_w  [5];
   logic busy_w [5];
   logic rdy_w  [5];

   int checks;
   int passed;
   int act_cnt   [5];
   int first_act [5];
   int busy_cnt  [5];
   int rdy_busy  [5];

   irda_sir_encoder d0 (
      .clk(clk), .rst_n(rst_n), .baud16_en(baud16_en), .bit_valid(bit_valid),
      .bit_data(bit_data), .mode_fixed(mode_fixed),
      .bit_ready(rdy_w[0]), .busy(busy_w[0]), .txd(txd_w[0]));

   irda_sir_encoder #(.FIX_CYC(7)) d1 (
      .clk(clk), .rst_n(rst_n), .baud16_en(baud16_en), .bit_valid(bit_valid),
      .bit_data(bit_data), .mode_fixed(mode_fixed),
      .bit_ready(rdy_w[1]), .busy(busy_w[1]), .txd(txd_w[1]));

   irda_sir_encoder #(.FIX_CYC(100)) d2 (
      .clk(clk), .rst_n(rst_n), .baud16_en(baud16_en), .bit_valid(bit_valid),
      .bit_data(bit_data), .mode_fixed(mode_fixed),
      .bit_ready(rdy_w[2]), .busy(busy_w[2]), .txd(txd_w[2]));

   irda_sir_encoder #(.INVERT_OUT(1'b1)) d3 (
      .clk(clk), .rst_n(rst_n), .baud16_en(baud16_en), .bit_valid(bit_valid),
      .bit_data(bit_data), .mode_fixed(mode_fixed),
      .bit_ready(rdy_w[3]), .busy(busy_w[3]), .txd(txd_w[3]));

   irda_sir_encoder #(.OSR(8), .PULSE_OFS(2), .PULSE_W(2)) d4 (
      .clk(clk), .rst_n(rst_n), .baud16_en(baud16_en), .bit_valid(bit_valid),
      .bit_data(bit_data), .mode_fixed(mode_fixed),
      .bit_ready(rdy_w[4]), .busy(busy_w[4]), .txd(txd_w[4]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversampling strobe every 4 clk, updated on the falling edge
   initial begin
      int c;
      c = 0;
      baud16_en = 1'b0;
      forever begin
         @(negedge clk);
         baud16_en = (c == 0);
         c = (c + 1) % 4;
      end
   end

   function automatic logic inv_of(input int i);
      return (i == 3);
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      bit_valid = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_strobe();
      for (int j = 0; j < 8; j++) begin
         if (baud16_en) break;
         step();
      end
      if (!baud16_en) begin
         checks++;
         $display("FAIL strobe_align: baud16_en=%b required 1", baud16_en);
      end
   endtask

   // Send one bit on a strobe edge, then observe n cycles (step k=0 follows the transfer edge)
   task automatic run_bit(input logic d, input int n, input int tog);
      for (int i = 0; i < 5; i++) begin
         act_cnt[i] = 0; first_act[i] = -1; busy_cnt[i] = 0; rdy_busy[i] = 0;
      end
      wait_strobe();
      bit_valid = 1'b1;
      bit_data = d;
      for (int k = 0; k < n; k++) begin
         step();
         if (k == 0) bit_valid = 1'b0;
         if (k == tog) begin
            bit_data = ~bit_data;
            mode_fixed = ~mode_fixed;
         end
         for (int i = 0; i < 5; i++) begin
            if (txd_w[i] !== inv_of(i)) begin
               act_cnt[i]++;
               if (first_act[i] < 0) first_act[i] = k;
            end
            if (busy_w[i] === 1'b1) busy_cnt[i]++;
            if (busy_w[i] === 1'b1 && rdy_w[i] === 1'b1) rdy_busy[i]++;
         end
      end
   endtask

   task automatic test_reset();
      bit_valid = 1'b0; bit_data = 1'b1; mode_fixed = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (busy_w[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_w[i]);
         else passed++;
         checks++;
         if (rdy_w[i] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", i, rdy_w[i]);
         else passed++;
         checks++;
         if (txd_w[i] !== inv_of(i)) $display("FAIL reset_txd[%0d]: got %b want %b", i, txd_w[i], inv_of(i));
         else passed++;
      end
   endtask

   task automatic test_ratio_zero();
      do_reset();
      mode_fixed = 1'b0;
      run_bit(1'b0, 80, -1);
      checks++;
      if (act_cnt[0] !== 12) $display("FAIL ratio_width: got %0d want 12", act_cnt[0]);
      else passed++;
      checks++;
      if (first_act[0] !== 1) $display("FAIL ratio_start: got %0d want 1", first_act[0]);
      else passed++;
      checks++;
      if (busy_cnt[0] !== 64) $display("FAIL ratio_busy: got %0d want 64", busy_cnt[0]);
      else passed++;
      checks++;
      if (act_cnt[3] !== 12) $display("FAIL invert_width: got %0d want 12", act_cnt[3]);
      else passed++;
      checks++;
      if (act_cnt[4] !== 8) $display("FAIL osr8_width: got %0d want 8", act_cnt[4]);
      else passed++;
      checks++;
      if (first_act[4] !== 9) $display("FAIL osr8_start: got %0d want 9", first_act[4]);
      else passed++;
      checks++;
      if (busy_cnt[4] !== 32) $display("FAIL osr8_busy: got %0d want 32", busy_cnt[4]);
      else passed++;
   endtask

   task automatic test_bit_one();
      do_reset();
      mode_fixed = 1'b0;
      run_bit(1'b1, 80, 10);
      checks++;
      if (act_cnt[0] !== 0) $display("FAIL one_nopulse: got %0d want 0", act_cnt[0]);
      else passed++;
      checks++;
      if (act_cnt[1] !== 0) $display("FAIL one_nopulse_fix: got %0d want 0", act_cnt[1]);
      else passed++;
      checks++;
      if (busy_cnt[0] !== 64) $display("FAIL one_busy: got %0d want 64", busy_cnt[0]);
      else passed++;
      checks++;
      if (rdy_busy[0] !== 1) $display("FAIL one_ready_in_bit: got %0d want 1", rdy_busy[0]);
      else passed++;
   endtask

   task automatic test_fixed();
      do_reset();
      mode_fixed = 1'b1;
      run_bit(1'b0, 80, -1);
      checks++;
      if (act_cnt[1] !== 7) $display("FAIL fix7_width: got %0d want 7", act_cnt[1]);
      else passed++;
      checks++;
      if (first_act[1] !== 1) $display("FAIL fix7_start: got %0d want 1", first_act[1]);
      else passed++;
      checks++;
      if (act_cnt[2] !== 64) $display("FAIL fix100_trunc: got %0d want 64", act_cnt[2]);
      else passed++;
      checks++;
      if (act_cnt[0] !== 16) $display("FAIL fix16_width: got %0d want 16", act_cnt[0]);
      else passed++;
      checks++;
      if (busy_cnt[2] !== 64) $display("FAIL fix100_busy: got %0d want 64", busy_cnt[2]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic seq [3];
      int   xfer_t [3];
      int   rise_t [2];
      int   nx, nr, bcnt;
      logic prev, will_xfer;
      seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0;
      nx = 0; nr = 0; bcnt = 0; prev = 1'b0;
      for (int i = 0; i < 3; i++) xfer_t[i] = -1;
      for (int i = 0; i < 2; i++) rise_t[i] = -1;
      do_reset();
      mode_fixed = 1'b0;
      wait_strobe();
      bit_valid = 1'b1;
      bit_data = seq[0];
      for (int k = 0; k < 220; k++) begin
         will_xfer = bit_valid && (rdy_w[0] === 1'b1);
         step();
         if (will_xfer && nx < 3) begin
            xfer_t[nx] = k;
            nx++;
            if (nx < 3) bit_data = seq[nx];
            else bit_valid = 1'b0;
         end
         if (txd_w[0] === 1'b1 && prev === 1'b0 && nr < 2) begin
            rise_t[nr] = k;
            nr++;
         end
         prev = txd_w[0];
         if (k < 192 && busy_w[0] === 1'b1) bcnt++;
      end
      checks++;
      if (xfer_t[1] - xfer_t[0] !== 64) $display("FAIL b2b_xfer01: got %0d want 64", xfer_t[1] - xfer_t[0]);
      else passed++;
      checks++;
      if (xfer_t[2] - xfer_t[1] !== 64) $display("FAIL b2b_xfer12: got %0d want 64", xfer_t[2] - xfer_t[1]);
      else passed++;
      checks++;
      if (rise_t[0] !== 1) $display("FAIL b2b_rise0: got %0d want 1", rise_t[0]);
      else passed++;
      checks++;
      if (rise_t[1] !== 129) $display("FAIL b2b_rise2: got %0d want 129", rise_t[1]);
      else passed++;
      checks++;
      if (bcnt !== 192) $display("FAIL b2b_busy: got %0d want 192", bcnt);
      else passed++;
      checks++;
      if (busy_w[0] !== 1'b0) $display("FAIL b2b_idle_end: got %b want 0", busy_w[0]);
      else passed++;
   endtask

   task automatic test_invert_reset();
      int lows, bcnt;
      lows = 0; bcnt = 0;
      do_reset();
      mode_fixed = 1'b0;
      wait_strobe();
      bit_valid = 1'b1;
      bit_data = 1'b0;
      step();
      bit_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (txd_w[3] !== 1'b0) $display("FAIL inv_mid_pulse: got %b want 0", txd_w[3]);
      else passed++;
      rst_n = 1'b0;
      step();
      checks++;
      if (txd_w[3] !== 1'b1) $display("FAIL inv_rst_txd: got %b want 1", txd_w[3]);
      else passed++;
      checks++;
      if (busy_w[3] !== 1'b0) $display("FAIL inv_rst_busy: got %b want 0", busy_w[3]);
      else passed++;
      checks++;
      if (rdy_w[3] !== 1'b1) $display("FAIL inv_rst_ready: got %b want 1", rdy_w[3]);
      else passed++;
      rst_n = 1'b1;
      for (int k = 0; k < 80; k++) begin
         step();
         if (txd_w[3] !== 1'b1) lows++;
         if (busy_w[3] === 1'b1) bcnt++;
      end
      checks++;
      if (lows !== 0) $display("FAIL inv_no_resume: got %0d low cycles want 0", lows);
      else passed++;
      checks++;
      if (bcnt !== 0) $display("FAIL inv_stay_idle: got %0d busy cycles want 0", bcnt);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n = 1'b0;
      bit_valid = 1'b0;
      bit_data = 1'b1;
      mode_fixed = 1'b0;
      test_reset();
      test_ratio_zero();
      test_bit_one();
      test_fixed();
      test_back_to_back();
      test_invert_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
